// File: rtl/eth_frame_rx.sv
// Ethernet frame receiver: hunts preamble/SFD, captures DA/SA/length, forwards the
// data field and checks the trailing FCS against a CRC32 taken over the data bytes only.
module eth_frame_rx #(
  parameter int pMAX_LEN = 1500,
  parameter int pMIN_PRE = 6
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic [7:0]  idata_byte,
  input  logic        ivalid,
  output logic [2:0]  ost,
  output logic [7:0]  odata_byte,
  output logic        odata_valid,
  output logic [47:0] odaddr,
  output logic [47:0] osaddr,
  output logic [10:0] olen,
  output logic        oframe_done,
  output logic        ocrc_ok,
  output logic [1:0]  oerr
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DROP     = 3'd2;
  localparam logic [2:0] ST_DADDR    = 3'd3;
  localparam logic [2:0] ST_SADDR    = 3'd4;
  localparam logic [2:0] ST_LENTYPE  = 3'd5;
  localparam logic [2:0] ST_DATA     = 3'd6;
  localparam logic [2:0] ST_FCS      = 3'd7;

  localparam logic [3:0]  MIN_PRE = 4'(pMIN_PRE);
  localparam logic [15:0] MAX_LEN = 16'(pMAX_LEN);
  localparam logic [31:0] POLY    = 32'h04C1_1DB7;

  // Byte-wise CRC32, MSB of the byte enters first, no reflection or inversion.
  function automatic logic [31:0] crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  logic [2:0]  st_reg, st_next;
  logic [3:0]  pre_cnt_reg, pre_cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [10:0] data_cnt_reg, data_cnt_next;
  logic [7:0]  len_hi_reg, len_hi_next;
  logic [31:0] crc_reg, crc_next;
  logic        mismatch_reg, mismatch_next;
  logic [7:0]  data_byte_reg, data_byte_next;
  logic        data_valid_reg, data_valid_next;
  logic [47:0] daddr_reg, daddr_next;
  logic [47:0] saddr_reg, saddr_next;
  logic [10:0] len_reg, len_next;
  logic        done_reg, done_next;
  logic        crc_ok_reg, crc_ok_next;
  logic [1:0]  err_reg, err_next;

  logic [15:0] len_field;
  logic        len_ok;
  logic        sfd_ok;
  logic [7:0]  fcs_exp;

  // The length check uses the full 16-bit field, before truncation to 11 bits.
  assign len_field = {len_hi_reg, idata_byte};
  assign len_ok    = (len_field != 16'd0) && (len_field <= MAX_LEN);
  assign sfd_ok    = (idata_byte == 8'hD5) && (pre_cnt_reg >= MIN_PRE);

  always_comb begin
    case (idx_reg[1:0])
      2'd0:    fcs_exp = crc_reg[31:24];
      2'd1:    fcs_exp = crc_reg[23:16];
      2'd2:    fcs_exp = crc_reg[15:8];
      default: fcs_exp = crc_reg[7:0];
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) st_reg <= ST_IDLE;
    else         st_reg <= st_next;
  end

  always_comb begin
    st_next = st_reg;
    if (!ivalid) begin
      st_next = ST_IDLE;
    end else begin
      case (st_reg)
        ST_IDLE:     if (idata_byte == 8'h55) st_next = ST_PREAMBLE;
        ST_PREAMBLE: begin
          if (sfd_ok)                        st_next = ST_DADDR;
          else if (idata_byte != 8'h55)      st_next = ST_IDLE;
        end
        ST_DROP:     st_next = ST_DROP;
        ST_DADDR:    if (idx_reg == 3'd5) st_next = ST_SADDR;
        ST_SADDR:    if (idx_reg == 3'd5) st_next = ST_LENTYPE;
        ST_LENTYPE:  if (idx_reg == 3'd1) st_next = len_ok ? ST_DATA : ST_DROP;
        ST_DATA:     if (data_cnt_reg == 11'd1) st_next = ST_FCS;
        ST_FCS:      if (idx_reg == 3'd3) st_next = ST_IDLE;
        default:     st_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_cnt_next    = pre_cnt_reg;
    idx_next        = idx_reg;
    data_cnt_next   = data_cnt_reg;
    len_hi_next     = len_hi_reg;
    crc_next        = crc_reg;
    mismatch_next   = mismatch_reg;
    data_byte_next  = data_byte_reg;
    data_valid_next = 1'b0;
    daddr_next      = daddr_reg;
    saddr_next      = saddr_reg;
    len_next        = len_reg;
    done_next       = 1'b0;
    crc_ok_next     = crc_ok_reg;
    err_next        = 2'b00;
    if (!ivalid) begin
      idx_next = 3'd0;
      // Losing ivalid anywhere from the first DA byte to the last FCS byte is a truncation.
      if (st_reg >= ST_DADDR) err_next = 2'b01;
    end else begin
      case (st_reg)
        ST_IDLE: if (idata_byte == 8'h55) pre_cnt_next = 4'd1;
        ST_PREAMBLE: begin
          if (idata_byte == 8'h55) begin
            if (pre_cnt_reg != 4'd15) pre_cnt_next = pre_cnt_reg + 4'd1;
          end else if (sfd_ok) begin
            idx_next      = 3'd0;
            crc_next      = 32'd0;
            mismatch_next = 1'b0;
          end
        end
        ST_DADDR: begin
          daddr_next = {daddr_reg[39:0], idata_byte};
          idx_next   = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
        ST_SADDR: begin
          saddr_next = {saddr_reg[39:0], idata_byte};
          idx_next   = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
        ST_LENTYPE: begin
          if (idx_reg == 3'd0) begin
            len_hi_next = idata_byte;
            idx_next    = 3'd1;
          end else begin
            idx_next = 3'd0;
            if (len_ok) begin
              len_next      = len_field[10:0];
              data_cnt_next = len_field[10:0];
            end else begin
              err_next = 2'b10;
            end
          end
        end
        ST_DATA: begin
          data_byte_next  = idata_byte;
          data_valid_next = 1'b1;
          crc_next        = crc32_d8(idata_byte, crc_reg);
          data_cnt_next   = data_cnt_reg - 11'd1;
        end
        ST_FCS: begin
          mismatch_next = mismatch_reg | (idata_byte != fcs_exp);
          if (idx_reg == 3'd3) begin
            idx_next    = 3'd0;
            done_next   = 1'b1;
            crc_ok_next = ~mismatch_next;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pre_cnt_reg    <= '0;
      idx_reg        <= '0;
      data_cnt_reg   <= '0;
      len_hi_reg     <= '0;
      crc_reg        <= '0;
      mismatch_reg   <= 1'b0;
      data_byte_reg  <= '0;
      data_valid_reg <= 1'b0;
      daddr_reg      <= '0;
      saddr_reg      <= '0;
      len_reg        <= '0;
      done_reg       <= 1'b0;
      crc_ok_reg     <= 1'b0;
      err_reg        <= '0;
    end else begin
      pre_cnt_reg    <= pre_cnt_next;
      idx_reg        <= idx_next;
      data_cnt_reg   <= data_cnt_next;
      len_hi_reg     <= len_hi_next;
      crc_reg        <= crc_next;
      mismatch_reg   <= mismatch_next;
      data_byte_reg  <= data_byte_next;
      data_valid_reg <= data_valid_next;
      daddr_reg      <= daddr_next;
      saddr_reg      <= saddr_next;
      len_reg        <= len_next;
      done_reg       <= done_next;
      crc_ok_reg     <= crc_ok_next;
      err_reg        <= err_next;
    end
  end

  assign ost         = st_reg;
  assign odata_byte  = data_byte_reg;
  assign odata_valid = data_valid_reg;
  assign odaddr      = daddr_reg;
  assign osaddr      = saddr_reg;
  assign olen        = len_reg;
  assign oframe_done = done_reg;
  assign ocrc_ok     = crc_ok_reg;
  assign oerr        = err_reg;

endmodule
